// File: rtl/tc_lfsr_pkg.sv
// tc_lfsr_pkg: shared definitions for the tc_lfsrn_gen pattern generator.
//   - burst_state_e : burst engine state encoding (IDLE=0, BURST=1)
//   - DEFAULT_TAPS  : Galois feedback mask for the 8-bit configuration
//   - DEFAULT_SEED  : reset value for the 8-bit configuration
package tc_lfsr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_e;

  localparam logic [7:0] DEFAULT_TAPS = 8'h38;
  localparam logic [7:0] DEFAULT_SEED = 8'h01;

endpackage

// File: rtl/tc_lfsrn_gen_if.sv
// tc_lfsrn_gen_if: control/data bundle of the LFSR/MISR generator.
//   master : drives SET_EN/SET_VAL, SI_EN/SI, MISR_EN/DIN, RUN, START/COUNT;
//            observes OUT, SO, BUSY, DONE, ZERO.
//   slave  : the generator itself (mirror image of master).
interface tc_lfsrn_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic             SET_EN;
  logic [WIDTH-1:0] SET_VAL;
  logic             SI_EN;
  logic             SI;
  logic             MISR_EN;
  logic [WIDTH-1:0] DIN;
  logic             RUN;
  logic             START;
  logic [CNT_W-1:0] COUNT;
  logic [WIDTH-1:0] OUT;
  logic             SO;
  logic             BUSY;
  logic             DONE;
  logic             ZERO;

  modport master (
    output SET_EN, SET_VAL, SI_EN, SI, MISR_EN, DIN, RUN, START, COUNT,
    input  OUT, SO, BUSY, DONE, ZERO
  );

  modport slave (
    input  SET_EN, SET_VAL, SI_EN, SI, MISR_EN, DIN, RUN, START, COUNT,
    output OUT, SO, BUSY, DONE, ZERO
  );

endinterface

// File: rtl/tc_lfsr_burst_ctl.sv
// tc_lfsr_burst_ctl: counted burst-step engine.
//   clk, srst : clock and synchronous active-high reset
//   start     : burst request, sampled on a single edge while idle
//   count     : number of steps requested (0 => immediate DONE, no steps)
//   abort     : a higher-priority register operation this cycle; kills a burst
//   step      : advance the LFSR on this edge
//   busy      : burst in progress
//   done      : one-cycle pulse after the final step (or after a zero-length request)
module tc_lfsr_burst_ctl
  import tc_lfsr_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             step,
  output logic             busy,
  output logic             done
);

  burst_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The accepting edge only loads the counter; stepping starts next edge.
        if (start) begin
          if (count != '0) begin
            state_d = BURST;
            cnt_d   = count;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      BURST: begin
        if (abort) begin
          // The competing load/shift/compaction owns OUT; no completion pulse.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BURST);
  assign done = done_q;

endmodule

// File: rtl/tc_lfsrn_gen.sv
// tc_lfsrn_gen: WIDTH-bit Galois LFSR with programmable taps, MISR compaction,
// serial shift-in, parallel load and a counted burst-step engine.
//   phi  : clock, rising edge
//   RST  : synchronous active-high reset (OUT<=SEED, burst aborted, no DONE)
//   bus  : tc_lfsrn_gen_if slave modport
//          inputs  SET_EN/SET_VAL, SI_EN/SI, MISR_EN/DIN, RUN, START/COUNT
//          outputs OUT, SO (=OUT[0]), BUSY, DONE, ZERO (=OUT==0)
// OUT update priority: RST > SET_EN > SI_EN > MISR_EN > step (BUSY|RUN) > hold.
module tc_lfsrn_gen
  import tc_lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
  parameter int               CNT_W = 8
) (
  input  logic                phi,
  input  logic                RST,
  tc_lfsrn_gen_if.slave       bus
);

  // Top bit is always fed by OUT[0]; TAPS[WIDTH-1] is deliberately ignored.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] fb_mask;
    fb_mask = {1'b0, TAPS[WIDTH-2:0]} & {WIDTH{q[0]}};
    return {q[0], q[WIDTH-1:1]} ^ fb_mask;
  endfunction

  logic [WIDTH-1:0] out_q, out_d;
  logic             burst_step;
  logic             burst_busy;
  logic             burst_done;
  logic             reg_op;

  // Any explicit register operation pre-empts (and aborts) a burst.
  assign reg_op = bus.SET_EN | bus.SI_EN | bus.MISR_EN;

  tc_lfsr_burst_ctl #(
    .CNT_W (CNT_W)
  ) u_burst_ctl (
    .clk   (phi),
    .srst  (RST),
    .start (bus.START),
    .count (bus.COUNT),
    .abort (reg_op),
    .step  (burst_step),
    .busy  (burst_busy),
    .done  (burst_done)
  );

  always_comb begin
    out_d = out_q;
    if (bus.SET_EN) begin
      out_d = bus.SET_VAL;
    end else if (bus.SI_EN) begin
      out_d = {bus.SI, out_q[WIDTH-1:1]};
    end else if (bus.MISR_EN) begin
      out_d = lfsr_next(out_q) ^ bus.DIN;
    end else if (burst_step || bus.RUN) begin
      // RUN during a burst still yields a single step per edge.
      out_d = lfsr_next(out_q);
    end
  end

  always_ff @(posedge phi) begin
    if (RST) begin
      out_q <= SEED;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.OUT  = out_q;
  assign bus.SO   = out_q[0];
  assign bus.ZERO = (out_q == '0);
  assign bus.BUSY = burst_busy;
  assign bus.DONE = burst_done;

endmodule

// File: tb/tb_tc_lfsrn_gen.sv
// tb_tc_lfsrn_gen: table-driven directed vectors, hand-written burst-abort
// sequences and randomized stimulus checked against a behavioural model.
module tb_tc_lfsrn_gen;

  localparam int W     = 8;
  localparam int TAPSV = 'h38;
  localparam int SEEDV = 'h01;

  logic phi = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 phi = ~phi;

  tc_lfsrn_gen_if #(.WIDTH(W), .CNT_W(8)) bus ();

  tc_lfsrn_gen #(
    .WIDTH (W),
    .TAPS  (8'h38),
    .SEED  (8'h01),
    .CNT_W (8)
  ) dut (
    .phi (phi),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- behavioural reference model ----------------
  int m_out;
  int m_rem;   // burst steps still owed; >0 means busy
  bit m_done;

  function automatic int ref_step(input int q);
    int fb;
    fb = (1 << (W - 1)) | (TAPSV & ((1 << (W - 1)) - 1));
    return (q >> 1) ^ (((q & 1) != 0) ? fb : 0);
  endfunction

  task automatic model_edge();
    int nxt;
    int rem_old;
    bit op;
    if (rst) begin
      m_out = SEEDV; m_rem = 0; m_done = 0;
      return;
    end
    op      = bus.SET_EN || bus.SI_EN || bus.MISR_EN;
    rem_old = m_rem;
    m_done  = 0;
    nxt     = m_out;
    if (bus.SET_EN)       nxt = int'(bus.SET_VAL);
    else if (bus.SI_EN)   nxt = (m_out >> 1) | (int'(bus.SI) << (W - 1));
    else if (bus.MISR_EN) nxt = ref_step(m_out) ^ int'(bus.DIN);
    else if (rem_old > 0 || bus.RUN) nxt = ref_step(m_out);
    if (rem_old > 0) begin
      if (op) m_rem = 0;
      else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_done = 1;
      end
    end else if (bus.START) begin
      if (bus.COUNT == 0) m_done = 1;
      else m_rem = int'(bus.COUNT);
    end
    m_out = nxt;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eo, input logic eb, input logic ed);
    chk({tag, " OUT"},  32'(bus.OUT),  32'(eo));
    chk({tag, " SO"},   32'(bus.SO),   32'(eo[0]));
    chk({tag, " BUSY"}, 32'(bus.BUSY), 32'(eb));
    chk({tag, " DONE"}, 32'(bus.DONE), 32'(ed));
    chk({tag, " ZERO"}, 32'(bus.ZERO), 32'(eo == 8'h00));
  endtask

  task automatic check_model(input string tag);
    check_all(tag, 8'(m_out), m_rem > 0, m_done);
  endtask

  task automatic clear_inputs();
    rst = 0;
    bus.SET_EN = 0; bus.SET_VAL = '0; bus.SI_EN = 0; bus.SI = 0;
    bus.MISR_EN = 0; bus.DIN = '0; bus.RUN = 0; bus.START = 0; bus.COUNT = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge phi);
    #1;
  endtask

  task automatic show(input string tag);
    $display("%s: OUT=0x%02h SO=%0b BUSY=%0b DONE=%0b ZERO=%0b",
             tag, bus.OUT, bus.SO, bus.BUSY, bus.DONE, bus.ZERO);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       set_en;
    logic [7:0] set_val;
    logic       si_en;
    logic       si;
    logic       misr_en;
    logic [7:0] din;
    logic       run;
    logic       start;
    logic [7:0] count;
    logic [7:0] exp_out;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic se, input logic [7:0] sv, input logic sie, input logic si,
                              input logic me, input logic [7:0] din, input logic run,
                              input logic st, input logic [7:0] cnt,
                              input logic [7:0] eo, input logic eb, input logic ed);
    vec_t v;
    v.set_en = se; v.set_val = sv; v.si_en = sie; v.si = si; v.misr_en = me; v.din = din;
    v.run = run; v.start = st; v.count = cnt; v.exp_out = eo; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  logic [7:0] si_exp [8];
  logic [7:0] run_exp [5];

  initial begin
    si_exp  = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    run_exp = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

    //            se sv    sie si me din   run st cnt   exp  busy done
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'h00, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'd0, si_exp[i], 0, 0));
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'h01, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'd0, run_exp[i], 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'hB3, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'hB3, 0, 0));
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'h01, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h0F, 0, 0, 8'd0, 8'hB7, 0, 0));
    vecs.push_back(mk(1, 8'h55, 0, 0, 1, 8'h0F, 0, 0, 8'd0, 8'h55, 0, 0));
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'h01, 0, 0));
    // burst of 4 from 0x01
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'd4, 8'h01, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'hB8, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'h5C, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'h2E, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'h17, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'h17, 0, 0));
    // zero-length burst
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'd0, 8'h17, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'h17, 0, 0));
    // burst of 4 with START re-asserted and RUN high mid-burst
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'd4, 8'h17, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'd2, 8'hB3, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'd0, 8'hE1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'hC8, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'h64, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0, 8'h64, 0, 0));
  end

  // ---------------- test sequence ----------------
  initial begin
    clear_inputs();
    m_out = 0; m_rem = 0; m_done = 0;

    // reset
    rst = 1;
    tick();
    show("reset");
    check_all("reset", 8'h01, 0, 0);
    rst = 0;

    // directed table
    for (int i = 0; i < vecs.size(); i++) begin
      bus.SET_EN = vecs[i].set_en; bus.SET_VAL = vecs[i].set_val;
      bus.SI_EN  = vecs[i].si_en;  bus.SI      = vecs[i].si;
      bus.MISR_EN = vecs[i].misr_en; bus.DIN  = vecs[i].din;
      bus.RUN    = vecs[i].run;    bus.START   = vecs[i].start;
      bus.COUNT  = vecs[i].count;
      tick();
      show($sformatf("vec %0d", i));
      check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_busy, vecs[i].exp_done);
    end
    clear_inputs();

    // burst of 10 aborted by SET_EN on step 3
    bus.SET_EN = 1; bus.SET_VAL = 8'h01; tick(); clear_inputs();
    bus.START = 1; bus.COUNT = 8'd10; tick(); clear_inputs();
    show("abort_set start"); check_all("abort_set start", 8'h01, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); show($sformatf("abort_set step %0d", i + 1)); check_model("abort_set step");
    end
    bus.SET_EN = 1; bus.SET_VAL = 8'hA5; tick(); clear_inputs();
    show("abort_set load"); check_all("abort_set load", 8'hA5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); show("abort_set after"); check_all("abort_set after", 8'hA5, 0, 0);
    end

    // burst of 6 aborted by RST on step 5
    bus.START = 1; bus.COUNT = 8'd6; tick(); clear_inputs();
    for (int i = 0; i < 4; i++) begin
      tick(); show($sformatf("abort_rst step %0d", i + 1)); check_model("abort_rst step");
    end
    rst = 1; tick(); rst = 0;
    show("abort_rst reset"); check_all("abort_rst reset", 8'h01, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); show("abort_rst after"); check_all("abort_rst after", 8'h01, 0, 0);
    end

    // lock-up: all-zero state never leaves under RUN
    bus.SET_EN = 1; bus.SET_VAL = 8'h00; tick(); clear_inputs();
    bus.RUN = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); show("lockup"); check_all("lockup", 8'h00, 0, 0);
    end
    clear_inputs();

    // randomized stimulus against the model
    for (int i = 0; i < 300; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      bus.SET_EN  = ($urandom_range(0, 99) < 4);
      bus.SET_VAL = 8'($urandom);
      bus.SI_EN   = ($urandom_range(0, 99) < 5);
      bus.SI      = 1'($urandom);
      bus.MISR_EN = ($urandom_range(0, 99) < 5);
      bus.DIN     = 8'($urandom);
      bus.RUN     = ($urandom_range(0, 99) < 20);
      bus.START   = ($urandom_range(0, 99) < 15);
      bus.COUNT   = 8'($urandom_range(0, 6));
      tick();
      show($sformatf("rand %0d", i));
      check_model($sformatf("rand%0d", i));
    end
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
